// File: rtl/booth_pkg.sv
// Shared control encodings for the Booth multiplier datapath and its controller.
package booth_pkg;

    // A-register control pair {a1,a2}
    typedef enum logic [1:0] {
        A_HOLD = 2'b00,
        A_SHR  = 2'b01,
        A_LOAD = 2'b10,
        A_CLR  = 2'b11
    } a_ctrl_e;

    // Q-register control pair {q1,q2}
    typedef enum logic [1:0] {
        Q_HOLD = 2'b00,
        Q_SHR  = 2'b01,
        Q_LOAD = 2'b10,
        Q_CLR  = 2'b11
    } q_ctrl_e;

endpackage

// File: rtl/booth_addsub.sv
// Combinational N-bit adder/subtractor, wraps modulo 2^N.
module booth_addsub #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] y
);

    // sub=0 -> a+b, sub=1 -> a-b
    always_comb begin
        y = sub ? (a - b) : (a + b);
    end

endmodule

// File: rtl/booth_datapath.sv
// Radix-2 Booth multiplier datapath: M, A (WIDTH+1), Q, Q-1 and a saturating
// step counter, all steered by an external control unit.
module booth_datapath
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    input  logic                 q1,
    input  logic                 q2,
    input  logic                 a1,
    input  logic                 a2,
    input  logic                 m1,
    input  logic                 alu,
    input  logic                 count,
    output logic                 c1,
    output logic                 c2,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] m_reg;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q_m1;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   alu_y;
    a_ctrl_e          a_op;
    q_ctrl_e          q_op;

    assign a_op  = a_ctrl_e'({a1, a2});
    assign q_op  = q_ctrl_e'({q1, q2});
    assign m_ext = {m_reg[WIDTH-1], m_reg};

    booth_addsub #(.N(WIDTH + 1)) u_addsub (
        .a   (a_reg),
        .b   (m_ext),
        .sub (alu),
        .y   (alu_y)
    );

    // Multiplicand register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     m_reg <= '0;
        else if (m1) m_reg <= mcand;
    end

    // Accumulator: hold / arithmetic shift right / load ALU / clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
        end else begin
            case (a_op)
                A_HOLD: ;
                A_SHR:  a_reg <= {a_reg[WIDTH], a_reg[WIDTH:1]};
                A_LOAD: a_reg <= alu_y;
                A_CLR:  a_reg <= '0;
            endcase
        end
    end

    // Multiplier register and Q-1; shift takes old A[0] so a joint A/Q shift is coherent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
            q_m1  <= 1'b0;
        end else begin
            case (q_op)
                Q_HOLD: ;
                Q_SHR: begin
                    q_reg <= {a_reg[0], q_reg[WIDTH-1:1]};
                    q_m1  <= q_reg[0];
                end
                Q_LOAD: begin
                    q_reg <= mplier;
                    q_m1  <= 1'b0;
                end
                Q_CLR: begin
                    q_reg <= '0;
                    q_m1  <= 1'b0;
                end
            endcase
        end
    end

    // Step counter: cleared on Q load, otherwise saturating increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (q_op == Q_LOAD) begin
            cnt <= '0;
        end else if (count && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Register-only outputs
    always_comb begin
        c1      = q_reg[0];
        c2      = q_m1;
        done    = (cnt == CNT_MAX);
        product = {a_reg[WIDTH-1:0], q_reg};
    end

endmodule

// File: tb/tb_booth_datapath.sv
// Self-checking bench for booth_datapath (WIDTH=4): directed cases plus random
// operand pairs checked against plain signed multiplication and bit tracking.
module tb_booth_datapath;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   mcand = '0;
    logic [W-1:0]   mplier = '0;
    logic           q1 = 1'b0, q2 = 1'b0, a1 = 1'b0, a2 = 1'b0;
    logic           m1 = 1'b0, alu = 1'b0, count = 1'b0;
    logic           c1, c2, done;
    logic [2*W-1:0] product;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    booth_datapath #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .mcand   (mcand),
        .mplier  (mplier),
        .q1      (q1),
        .q2      (q2),
        .a1      (a1),
        .a2      (a2),
        .m1      (m1),
        .alu     (alu),
        .count   (count),
        .c1      (c1),
        .c2      (c2),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then settle 1 time unit
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {q1, q2, a1, a2, m1, alu, count} = '0;
    endtask

    task automatic load_ops(input logic [W-1:0] mc, input logic [W-1:0] mp);
        mcand = mc; mplier = mp;
        m1 = 1'b1; {q1, q2} = 2'b10; {a1, a2} = 2'b11;
        tick();
        idle();
    endtask

    // one Booth step: ALU cycle chosen from {c1,c2}, then joint shift with count
    task automatic booth_step();
        case ({c1, c2})
            2'b10:   begin {a1, a2} = 2'b10; alu = 1'b1; end
            2'b01:   begin {a1, a2} = 2'b10; alu = 1'b0; end
            default: {a1, a2} = 2'b00;
        endcase
        tick();
        idle();
        {a1, a2} = 2'b01; {q1, q2} = 2'b01; count = 1'b1;
        tick();
        idle();
    endtask

    // full multiply with per-step tracking of multiplier bits through c1/c2
    task automatic run_booth(input string tag, input logic [W-1:0] mc, input logic [W-1:0] mp);
        int p;
        logic [2*W-1:0] exp_p;
        p = int'($signed(mc)) * int'($signed(mp));
        exp_p = p[2*W-1:0];
        load_ops(mc, mp);
        chk({tag, ".c1_load"}, 16'(c1), 16'(mp[0]));
        chk({tag, ".c2_load"}, 16'(c2), 16'h0);
        chk({tag, ".done_load"}, 16'(done), 16'h0);
        for (int k = 0; k < W; k++) begin
            booth_step();
            chk({tag, ".c2_step"}, 16'(c2), 16'(mp[k]));
            if (k < W - 1) chk({tag, ".c1_step"}, 16'(c1), 16'(mp[k+1]));
            chk({tag, ".done_step"}, 16'(done), 16'(k == W - 1));
        end
        chk({tag, ".product"}, 16'(product), 16'(exp_p));
    endtask

    initial begin
        // reset state, asserted before any clock edge
        #2;
        chk("rst.product", 16'(product), 16'h0);
        chk("rst.c1", 16'(c1), 16'h0);
        chk("rst.c2", 16'(c2), 16'h0);
        chk("rst.done", 16'(done), 16'h0);
        #10 rst = 1'b0;
        tick();

        // 3 * -2 = -6
        run_booth("p3xm2", 4'd3, 4'hE);
        chk("p3xm2.FA", 16'(product), 16'h00FA);

        // -8 * -8 = +64
        run_booth("m8xm8", 4'h8, 4'h8);
        chk("m8xm8.40", 16'(product), 16'h0040);

        // 7 * 7 = 49, then counter saturation
        run_booth("p7xp7", 4'd7, 4'd7);
        chk("p7xp7.31", 16'(product), 16'h0031);
        for (int i = 0; i < 3; i++) begin
            count = 1'b1;
            tick();
            idle();
            chk("sat.done", 16'(done), 16'h1);
            chk("sat.product", 16'(product), 16'h0031);
        end

        // Q-1 tracking on a single shift
        mplier = 4'b0001; {q1, q2} = 2'b10;
        tick();
        idle();
        chk("q0001.c1", 16'(c1), 16'h1);
        chk("q0001.c2", 16'(c2), 16'h0);
        {q1, q2} = 2'b01;
        tick();
        idle();
        chk("qshift.c1", 16'(c1), 16'h0);
        chk("qshift.c2", 16'(c2), 16'h1);

        // async reset mid-operation, then fresh 2x3
        load_ops(4'd5, 4'd6);
        booth_step();
        booth_step();
        #3 rst = 1'b1;
        #1;
        chk("arst.product", 16'(product), 16'h0);
        chk("arst.done", 16'(done), 16'h0);
        chk("arst.c1", 16'(c1), 16'h0);
        #2 rst = 1'b0;
        run_booth("p2xp3", 4'd2, 4'd3);
        chk("p2xp3.06", 16'(product), 16'h0006);

        // counter clear wins over increment when CNT=3
        load_ops(4'd1, 4'd1);
        for (int i = 0; i < 3; i++) begin
            count = 1'b1;
            tick();
            idle();
        end
        chk("cnt3.done", 16'(done), 16'h0);
        {q1, q2} = 2'b10; count = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            chk("clrprio.done", 16'(done), 16'h0);
            count = 1'b1;
            tick();
            idle();
        end
        chk("clrprio.done4", 16'(done), 16'h1);

        // random operand pairs
        for (int r = 0; r < 16; r++) begin
            run_booth("rand", W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/booth_datapath.md
BOOTH_DATAPATH -- requirements
Module: booth_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port mcand, input, WIDTH bits: signed multiplicand, sampled into M.
REQ-005 SHALL have port mplier, input, WIDTH bits: signed multiplier, sampled into Q.
REQ-006 SHALL have ports q1, q2, input, 1 bit each: Q-register control pair {q1,q2}.
REQ-007 SHALL have ports a1, a2, input, 1 bit each: A-register control pair {a1,a2}.
REQ-008 SHALL have port m1, input, 1 bit: load M from mcand.
REQ-009 SHALL have port alu, input, 1 bit: ALU operation, 0 = A+M, 1 = A-M.
REQ-010 SHALL have port count, input, 1 bit: step-counter increment enable.
REQ-011 SHALL have port c1, output, 1 bit: Q[0], fed back to the control unit.
REQ-012 SHALL have port c2, output, 1 bit: Q-1 bit, fed back to the control unit.
REQ-013 SHALL have port done, output, 1 bit: high when the step counter equals WIDTH.
REQ-014 SHALL have port product, output, 2*WIDTH bits: low 2*WIDTH bits of {A,Q}, two's complement.

Function
REQ-015 SHALL hold registers M (WIDTH bits), A (WIDTH+1 bits), Q (WIDTH bits), Q-1 (1 bit) and step counter CNT (clog2(WIDTH+1) bits).
REQ-016 SHALL compute the ALU in WIDTH+1 bits on sign-extended M: A+M or A-M, wrap-around modulo 2^(WIDTH+1).
REQ-017 SHALL decode {a1,a2}: 00 hold; 01 arithmetic shift right of A (MSB replicated); 10 load ALU result; 11 clear A.
REQ-018 SHALL decode {q1,q2}: 00 hold; 01 shift right, Q[WIDTH-1] <= old A[0], Q-1 <= old Q[0]; 10 load Q from mplier and clear Q-1; 11 clear Q and Q-1.
REQ-019 SHALL use pre-edge values for all registers when A and Q shift in the same cycle (A=01, Q=01), giving a coherent 2*WIDTH+2-bit shift.
REQ-020 SHALL load M when m1=1 and hold it otherwise.
REQ-021 SHALL clear CNT on any cycle with {q1,q2}=10.
REQ-022 SHALL, when count=1 and {q1,q2}≠10, increment CNT and saturate it at WIDTH; the clear takes priority when both occur.
REQ-023 SHALL drive c1, c2, done and product combinationally from registers only, never from inputs.
REQ-024 SHALL give single-cycle latency: a control applied in cycle n is visible on the outputs after edge n+1.
REQ-025 SHALL produce the exact signed product for all operand pairs, including mcand = mplier = -2^(WIDTH-1).

Reset
REQ-026 SHALL, while rst=1, force M, A, Q, Q-1 and CNT to 0 regardless of clk; outputs are then c1=0, c2=0, done=0, product=0.
REQ-027 SHALL, on reset asserted mid-operation, discard all partial results and resume from the all-zero state on the first edge after rst falls.

Structure
REQ-028 SHALL take the A-control and Q-control 2-bit encodings, as named constants, from the shared booth_pkg package.
REQ-029 SHALL implement the ALU as one sub-module, booth_addsub (WIDTH+1 bits, sub input, combinational); everything else SHALL be inline.

Verification (WIDTH=4; step = ALU as selected by {c1,c2}, then shift A and Q, count=1)
REQ-030 SHALL cover: mcand=3, mplier=-2 (4'hE), then 4 steps -> done=1 and product=8'hFA (-6).
REQ-031 SHALL cover: mcand=-8, mplier=-8, then 4 steps -> product=8'h40 (+64) with no overflow.
REQ-032 SHALL cover: mcand=7, mplier=7, then 4 steps -> product=8'h31; count held high 3 more cycles -> CNT stays 4 and done stays 1.
REQ-033 SHALL cover: Q loaded with 4'b0001 -> c1=1, c2=0; one Q shift -> c1=0, c2=1.
REQ-034 SHALL cover: rst pulsed asynchronously between edges after step 2 -> product=0 and done=0 immediately; a fresh 2x3 run then gives 8'h06.
REQ-035 SHALL cover: {q1,q2}=10 and count=1 in the same cycle with CNT=3 -> CNT=0.
